// File: rtl/seven_seg_decode.sv
// Purpose: capture a multiplexed 4-digit seven-segment display and rebuild the 16-bit hex value it shows.
// Latency: a digit is captured STABLE_CYCLES edges after it appears; a full frame reaches the outputs one edge after its last digit.
// Backpressure: valid/ready output; a frame that completes while the output is still held is dropped and overrun_out is set.
module seven_seg_decode #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] value_out,
  output logic [3:0]  err_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        overrun_out
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0]  prev_seg;
  logic [3:0]  prev_an;
  logic [7:0]  stable_cnt;
  logic [7:0]  cnt_next;
  logic        an_valid;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        pat_err;
  logic        same;
  logic        capture;
  logic [3:0]  cap_bit;
  logic [3:0]  mask;
  logic [15:0] frame_val;
  logic [3:0]  frame_err;
  logic        frame_done;
  logic        buf_free;

  // Exactly one active-low enable selects a digit; anything else is ignored.
  always_comb begin
    an_valid  = 1'b1;
    digit_sel = 2'd0;
    case (an_in)
      4'b1110: digit_sel = 2'd0;
      4'b1101: digit_sel = 2'd1;
      4'b1011: digit_sel = 2'd2;
      4'b0111: digit_sel = 2'd3;
      default: an_valid  = 1'b0;
    endcase
  end

  // Map the active-low segment pattern {a..g} to a hex nibble; unknown shapes flag an error.
  always_comb begin
    nibble  = 4'h0;
    pat_err = 1'b0;
    case (seg_in)
      7'b0000001: nibble = 4'h0;
      7'b1001111: nibble = 4'h1;
      7'b0010010: nibble = 4'h2;
      7'b0000110: nibble = 4'h3;
      7'b1001100: nibble = 4'h4;
      7'b0100100: nibble = 4'h5;
      7'b0100000: nibble = 4'h6;
      7'b0001111: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0000100: nibble = 4'h9;
      7'b0000010: nibble = 4'hA;
      7'b1100000: nibble = 4'hB;
      7'b0110001: nibble = 4'hC;
      7'b1000010: nibble = 4'hD;
      7'b0010000: nibble = 4'hE;
      7'b0111000: nibble = 4'hF;
      default:    pat_err = 1'b1;
    endcase
  end

  assign same = (seg_in == prev_seg) && (an_in == prev_an);

  // Stability counter saturates at the threshold so a held digit is captured only once per run.
  always_comb begin
    cnt_next = stable_cnt;
    if (!an_valid)
      cnt_next = 8'd0;
    else if (!same)
      cnt_next = 8'd1;
    else if (stable_cnt < STABLE_CNT)
      cnt_next = stable_cnt + 8'd1;
    capture = an_valid && (cnt_next == STABLE_CNT) && !(same && (stable_cnt == STABLE_CNT));
    cap_bit = capture ? (4'b0001 << digit_sel) : 4'b0000;
  end

  assign frame_done = (mask == 4'hF);
  assign buf_free   = !valid_out || ready_in;

  // Remember last cycle's inputs and advance the stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg   <= 7'h7F;
      prev_an    <= 4'hF;
      stable_cnt <= 8'd0;
    end else begin
      prev_seg   <= seg_in;
      prev_an    <= an_in;
      stable_cnt <= cnt_next;
    end
  end

  // Collect digits into the frame being assembled; a capture on the clearing edge seeds the next mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= 4'h0;
      frame_val <= 16'h0000;
      frame_err <= 4'h0;
    end else begin
      mask <= (frame_done ? 4'h0 : mask) | cap_bit;
      if (capture) begin
        frame_val[{digit_sel, 2'b00} +: 4] <= nibble;
        frame_err[digit_sel]               <= pat_err;
      end
    end
  end

  // Output buffer: load a finished frame when free, otherwise drop it and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_out   <= 16'h0000;
      err_out     <= 4'h0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (frame_done && buf_free) begin
        value_out <= frame_val;
        err_out   <= frame_err;
        valid_out <= 1'b1;
      end else begin
        if (frame_done)
          overrun_out <= 1'b1;
        if (valid_out && ready_in)
          valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_decode.sv
// Purpose: directed checks of seven_seg_decode with STABLE_CYCLES=4.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: ready_in is driven directly by the stimulus sequence.
module tb_seven_seg_decode;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PA = 7'b0000010;
  localparam logic [6:0] PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001;
  localparam logic [6:0] PF = 7'b0111000;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] IDLE = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value_out;
  logic [3:0]  err_out;
  logic        valid_out;
  logic        ready_in;
  logic        overrun_out;

  int total = 0;
  int bad   = 0;

  seven_seg_decode #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .value_out  (value_out),
    .err_out    (err_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one digit/pattern and hold it for n rising edges.
  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    seg_in   = BLANK;
    an_in    = IDLE;
    ready_in = 1'b1;
    #3;
    chk("rst_value",   value_out,   16'h0000);
    chk("rst_err",     {12'h0, err_out},     16'h0000);
    chk("rst_valid",   {15'h0, valid_out},   16'h0000);
    chk("rst_overrun", {15'h0, overrun_out}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal frame 4321
    hold(P1, D0, 4);
    hold(P2, D1, 4);
    hold(P3, D2, 4);
    chk("norm_not_yet", {15'h0, valid_out}, 16'h0000);
    hold(P4, D3, 4);
    hold(BLANK, IDLE, 1);
    chk("norm_valid", {15'h0, valid_out}, 16'h0001);
    chk("norm_value", value_out, 16'h4321);
    chk("norm_err",   {12'h0, err_out}, 16'h0000);
    hold(BLANK, IDLE, 1);
    chk("norm_valid_drop", {15'h0, valid_out}, 16'h0000);

    // Short hold: 7 held only 3 cycles must not be captured
    hold(P7, D0, 3);
    hold(P9, D0, 4);
    hold(P1, D1, 4);
    hold(P2, D2, 4);
    hold(P3, D3, 4);
    hold(BLANK, IDLE, 1);
    chk("short_valid", {15'h0, valid_out}, 16'h0001);
    chk("short_value", value_out, 16'h3219);
    hold(BLANK, IDLE, 1);
    chk("short_valid_drop", {15'h0, valid_out}, 16'h0000);

    // Unrecognised (blank) digit 2
    hold(PA, D0, 4);
    hold(PB, D1, 4);
    hold(BLANK, D2, 4);
    hold(PC, D3, 4);
    hold(BLANK, IDLE, 1);
    chk("inv_valid", {15'h0, valid_out}, 16'h0001);
    chk("inv_value", value_out, 16'hC0BA);
    chk("inv_err",   {12'h0, err_out}, 16'h0004);
    hold(BLANK, IDLE, 1);
    chk("inv_valid_drop", {15'h0, valid_out}, 16'h0000);

    // Backpressure: first frame held, second frame dropped
    ready_in = 1'b0;
    hold(P1, D0, 4);
    hold(P2, D1, 4);
    hold(P3, D2, 4);
    hold(P4, D3, 4);
    hold(BLANK, IDLE, 1);
    chk("bp_first_valid", {15'h0, valid_out}, 16'h0001);
    chk("bp_first_value", value_out, 16'h4321);
    chk("bp_no_overrun_yet", {15'h0, overrun_out}, 16'h0000);
    hold(P8, D0, 4);
    hold(P8, D1, 4);
    hold(P8, D2, 4);
    hold(P8, D3, 4);
    hold(BLANK, IDLE, 2);
    chk("bp_held_valid", {15'h0, valid_out}, 16'h0001);
    chk("bp_held_value", value_out, 16'h4321);
    chk("bp_held_err",   {12'h0, err_out}, 16'h0000);
    chk("bp_overrun",    {15'h0, overrun_out}, 16'h0001);
    ready_in = 1'b1;
    hold(BLANK, IDLE, 1);
    chk("bp_valid_fall", {15'h0, valid_out}, 16'h0000);
    chk("bp_overrun_sticky", {15'h0, overrun_out}, 16'h0001);

    // Invalid enables must not capture; digit 0 then completes the frame
    hold(P1, D1, 4);
    hold(P2, D2, 4);
    hold(P3, D3, 4);
    hold(P8, 4'b0000, 10);
    hold(P5, 4'b1100, 6);
    hold(BLANK, IDLE, 2);
    chk("inven_no_frame", {15'h0, valid_out}, 16'h0000);
    hold(P8, D0, 4);
    hold(BLANK, IDLE, 1);
    chk("inven_valid", {15'h0, valid_out}, 16'h0001);
    chk("inven_value", value_out, 16'h3218);
    ready_in = 1'b0;

    // Reset mid-frame with a frame held on the outputs
    hold(P0, D0, 4);
    hold(P1, D1, 4);
    hold(P2, D2, 4);
    chk("pre_rst_valid", {15'h0, valid_out}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_value",   value_out, 16'h0000);
    chk("arst_valid",   {15'h0, valid_out}, 16'h0000);
    chk("arst_overrun", {15'h0, overrun_out}, 16'h0000);
    chk("arst_err",     {12'h0, err_out}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ready_in = 1'b1;
    hold(PF, D3, 4);
    hold(BLANK, IDLE, 2);
    chk("post_rst_partial", {15'h0, valid_out}, 16'h0000);
    hold(P5, D0, 4);
    hold(P6, D1, 4);
    hold(P7, D2, 4);
    hold(BLANK, IDLE, 1);
    chk("post_rst_valid", {15'h0, valid_out}, 16'h0001);
    chk("post_rst_value", value_out, 16'hF765);
    chk("post_rst_overrun", {15'h0, overrun_out}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
